reshape_input: RTL and testbench

Narrow-to-wide packer for the audio feature path. It collects consecutive IN_WIDTH-word beats of 16-bit coefficients into one FRAME_LEN-word frame, for example 40 filterbank values. Once the frame is complete, it presents the frame as a single parallel vector. Both sides use valid/ready handshakes. It sits between a streaming feature source and the frame-wide consumer stages.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/reshape_input_if.sv | 37 +++
 rtl/reshape_input.sv | 116 +++++++++++
 tb/tb_reshape_input.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio feature path.
package audio_pkg;

    // One 16-bit feature coefficient.
    typedef logic [15:0] sample_t;

    // Filterbank values per feature frame.
    localparam int unsigned FEAT_LEN = 40;

    // Packer state: collecting beats, or holding a complete frame.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } reshape_state_t;

    // Integer ceiling division, used to size the beat count.
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/reshape_input_if.sv
// Stream-in / frame-out bundle for reshape_input.
// Optional macro RESHAPE_INPUT_LAST_EN adds s_last and frame_err.
interface reshape_input_if
    import audio_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned FRAME_LEN = FEAT_LEN
);

    logic                     s_valid;
    logic                     s_ready;
    sample_t [IN_WIDTH-1:0]   in;
    logic                     m_valid;
    logic                     m_ready;
    sample_t [FRAME_LEN-1:0]  out;
`ifdef RESHAPE_INPUT_LAST_EN
    logic                     s_last;
    logic                     frame_err;
`endif

`ifdef RESHAPE_INPUT_LAST_EN
    // Packer side.
    modport slave  (input  s_valid, in, s_last, m_ready,
                    output s_ready, m_valid, out, frame_err);
    // Source / consumer side.
    modport master (output s_valid, in, s_last, m_ready,
                    input  s_ready, m_valid, out, frame_err);
`else
    // Packer side.
    modport slave  (input  s_valid, in, m_ready,
                    output s_ready, m_valid, out);
    // Source / consumer side.
    modport master (output s_valid, in, m_ready,
                    input  s_ready, m_valid, out);
`endif

endinterface

// File: rtl/reshape_input.sv
// Narrow-to-wide packer: gathers IN_WIDTH-word beats into a FRAME_LEN-word frame
// and presents it as one parallel vector with a valid/ready handshake.
// Optional macro RESHAPE_INPUT_LAST_EN: s_last early termination plus sticky frame_err.
module reshape_input
    import audio_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned FRAME_LEN = FEAT_LEN
)(
    input  logic            clk,
    input  logic            reset,
    reshape_input_if.slave  bus
);

    localparam int unsigned     BEATS     = ceil_div(FRAME_LEN, IN_WIDTH);
    localparam int unsigned     CNT_W     = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    reshape_state_t          r_state;
    reshape_state_t          w_next_state;
    logic [CNT_W-1:0]        r_beat_cnt;
    sample_t [FRAME_LEN-1:0] r_frame;
    logic                    w_s_ready;
    logic                    w_m_valid;
    logic                    w_accept;
    logic                    w_last_beat;
    logic                    w_frame_done;
    logic [31:0]             w_cnt_ext;

    assign w_accept    = bus.s_valid && (r_state == ST_FILL);
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    assign w_cnt_ext   = 32'(r_beat_cnt);

`ifdef RESHAPE_INPUT_LAST_EN
    logic r_frame_err;
    logic w_early_last;
    logic w_missing_last;

    assign w_early_last   = w_accept && bus.s_last && !w_last_beat;
    assign w_missing_last = w_accept && !bus.s_last && w_last_beat;
    assign w_frame_done   = w_accept && (w_last_beat || bus.s_last);

    // Sticky framing error: early s_last or a full frame without s_last.
    always_ff @(posedge clk) begin
        if (!reset)
            r_frame_err <= 1'b0;
        else if (w_early_last || w_missing_last)
            r_frame_err <= 1'b1;
    end

    assign bus.frame_err = r_frame_err;
`else
    assign w_frame_done = w_accept && w_last_beat;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= ST_FILL;
        else
            r_state <= w_next_state;
    end

    // Next state and handshake outputs; both outputs depend on state only,
    // so m_ready never reaches s_ready combinationally.
    always_comb begin
        w_next_state = r_state;
        w_s_ready    = 1'b0;
        w_m_valid    = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_s_ready = 1'b1;
                if (w_frame_done)
                    w_next_state = ST_FULL;
            end
            ST_FULL: begin
                w_m_valid = 1'b1;
                if (bus.m_ready)
                    w_next_state = ST_FILL;
            end
            default: w_next_state = ST_FILL;
        endcase
    end

    // Beat counter: advances per accepted beat, wraps when the frame completes.
    always_ff @(posedge clk) begin
        if (!reset)
            r_beat_cnt <= '0;
        else if (w_frame_done)
            r_beat_cnt <= '0;
        else if (w_accept)
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end

    // Frame register: each word belongs to exactly one beat slot, so lanes of the
    // final beat that fall past FRAME_LEN simply have no destination.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame <= '0;
        end else if (w_accept) begin
            for (int unsigned k = 0; k < FRAME_LEN; k++) begin
                if ((k / IN_WIDTH) == w_cnt_ext)
                    r_frame[k] <= bus.in[k % IN_WIDTH];
`ifdef RESHAPE_INPUT_LAST_EN
                else if (w_early_last && ((k / IN_WIDTH) > w_cnt_ext))
                    r_frame[k] <= '0;
`endif
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = w_m_valid;
    assign bus.out     = r_frame;

endmodule

// File: tb/tb_reshape_input.sv
// Self-checking bench for reshape_input: an 8/40 instance and a 26/40 instance
// checked every cycle against a word-list reference model.
module tb_reshape_input;
    import audio_pkg::*;

    localparam int unsigned FL = 40;
    localparam int unsigned WA = 8;
    localparam int unsigned WB = 26;
`ifdef RESHAPE_INPUT_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reshape_input_if #(.IN_WIDTH(WA), .FRAME_LEN(FL)) ifa ();
    reshape_input_if #(.IN_WIDTH(WB), .FRAME_LEN(FL)) ifb ();

    reshape_input #(.IN_WIDTH(WA), .FRAME_LEN(FL)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifa.slave)
    );

    reshape_input #(.IN_WIDTH(WB), .FRAME_LEN(FL)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifb.slave)
    );

    // Reference model: the frame as a list of words filled in arrival order.
    sample_t     mfr  [2][FL];
    int unsigned mcnt [2];
    bit          mpend[2];
    bit          merr [2];

    function automatic logic [16*FL-1:0] pack_exp(input int id);
        logic [16*FL-1:0] v;
        for (int k = 0; k < FL; k++) v[k*16 +: 16] = mfr[id][k];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [16*FL-1:0] obs, input logic [16*FL-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int id = 0; id < 2; id++) begin
            mcnt[id] = 0; mpend[id] = 1'b0; merr[id] = 1'b0;
            for (int k = 0; k < FL; k++) mfr[id][k] = '0;
        end
    endtask

    task automatic mstep(input int id, input int unsigned w, input logic sv, input logic mr,
                         input logic sl, input sample_t bt[WB]);
        if (mpend[id]) begin
            if (mr) begin
                mpend[id] = 1'b0;
                mcnt[id]  = 0;
            end
        end else if (sv) begin
            for (int unsigned j = 0; j < w; j++) begin
                if (mcnt[id] < FL) begin
                    mfr[id][mcnt[id]] = bt[j];
                    mcnt[id]++;
                end
            end
            if (mcnt[id] == FL) begin
                mpend[id] = 1'b1;
                if (LAST_EN && !sl) merr[id] = 1'b1;
            end else if (LAST_EN && sl) begin
                for (int unsigned k = mcnt[id]; k < FL; k++) mfr[id][k] = '0;
                mcnt[id]  = FL;
                mpend[id] = 1'b1;
                merr[id]  = 1'b1;
            end
        end
    endtask

    // Check both DUTs against the model, advance the model with the driven
    // inputs, then move to just after the next rising edge.
    task automatic tick();
        sample_t ba[WB];
        sample_t bb[WB];
        logic    sla, slb;
        chk("a_s_ready", (16*FL)'(ifa.s_ready), (16*FL)'(!mpend[0]));
        chk("a_m_valid", (16*FL)'(ifa.m_valid), (16*FL)'(mpend[0]));
        chk("a_out",     ifa.out, pack_exp(0));
        chk("b_s_ready", (16*FL)'(ifb.s_ready), (16*FL)'(!mpend[1]));
        chk("b_m_valid", (16*FL)'(ifb.m_valid), (16*FL)'(mpend[1]));
        chk("b_out",     ifb.out, pack_exp(1));
        sla = 1'b0;
        slb = 1'b0;
`ifdef RESHAPE_INPUT_LAST_EN
        chk("a_frame_err", (16*FL)'(ifa.frame_err), (16*FL)'(merr[0]));
        chk("b_frame_err", (16*FL)'(ifb.frame_err), (16*FL)'(merr[1]));
        sla = ifa.s_last;
        slb = ifb.s_last;
`endif
        for (int j = 0; j < int'(WB); j++) begin ba[j] = '0; bb[j] = ifb.in[j]; end
        for (int j = 0; j < int'(WA); j++) ba[j] = ifa.in[j];
        if (!rst_n) begin
            mreset();
        end else begin
            mstep(0, WA, ifa.s_valid, ifa.m_ready, sla, ba);
            mstep(1, WB, ifb.s_valid, ifb.m_ready, slb, bb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic sv, input logic rnd, input int unsigned base);
        ifa.s_valid = sv;
        for (int unsigned j = 0; j < WA; j++) ifa.in[j] = rnd ? 16'($urandom) : 16'(base + j);
    endtask

    initial begin
        mreset();
        rst_n = 1'b0;
        ifa.s_valid = 1'b0; ifa.m_ready = 1'b0; ifa.in = '0;
        ifb.s_valid = 1'b0; ifb.m_ready = 1'b0; ifb.in = '0;
`ifdef RESHAPE_INPUT_LAST_EN
        ifa.s_last = 1'b0;
        ifb.s_last = 1'b0;
`endif
        @(posedge clk);
        #1;
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back frame of 0..39, consumer always ready.
        ifa.m_ready = 1'b1;
        ifb.m_ready = 1'b1;
        for (int unsigned b = 0; b < 5; b++) begin
            drive_a(1'b1, 1'b0, b * WA);
            tick();
        end
        drive_a(1'b0, 1'b0, 0);
        repeat (3) tick();

        // Backpressure: frame held while the source keeps offering 0xFFFF.
        ifa.m_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            drive_a(1'b1, 1'b1, 0);
            tick();
        end
        ifa.s_valid = 1'b1;
        for (int unsigned j = 0; j < WA; j++) ifa.in[j] = 16'hFFFF;
        repeat (10) tick();
        ifa.m_ready = 1'b1;
        tick();
        for (int b = 0; b < 5; b++) begin
            drive_a(1'b1, 1'b1, 0);
            tick();
        end
        drive_a(1'b0, 1'b0, 0);
        repeat (2) tick();

        // Non-divisible width: unused lanes of the last beat carry 0xDEAD.
        ifb.s_valid = 1'b1;
        for (int unsigned j = 0; j < WB; j++) ifb.in[j] = 16'(j);
        tick();
        for (int unsigned j = 0; j < WB; j++) ifb.in[j] = (j < 14) ? 16'(26 + j) : 16'hDEAD;
        tick();
        ifb.s_valid = 1'b0;
        repeat (3) tick();

        // Reset in the middle of a frame, then a fresh frame of 100..139.
        for (int b = 0; b < 3; b++) begin
            drive_a(1'b1, 1'b1, 0);
            tick();
        end
        drive_a(1'b0, 1'b0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int unsigned b = 0; b < 5; b++) begin
            drive_a(1'b1, 1'b0, 100 + b * WA);
            tick();
        end
        drive_a(1'b0, 1'b0, 0);
        repeat (4) tick();

        // Gapped source: valid every other cycle.
        for (int c = 0; c < 10; c++) begin
            drive_a((c % 2) == 0, 1'b1, 0);
            tick();
        end
        drive_a(1'b0, 1'b0, 0);
        repeat (3) tick();

        // Random traffic on both instances.
        for (int c = 0; c < 400; c++) begin
            drive_a(1'($urandom_range(0, 3) != 0), 1'b1, 0);
            ifa.m_ready = 1'($urandom_range(0, 2) != 0);
            ifb.s_valid = 1'($urandom_range(0, 1));
            for (int unsigned j = 0; j < WB; j++) ifb.in[j] = 16'($urandom);
            ifb.m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drive_a(1'b0, 1'b0, 0);
        ifb.s_valid = 1'b0;
        ifa.m_ready = 1'b1;
        ifb.m_ready = 1'b1;
        repeat (2) tick();

`ifdef RESHAPE_INPUT_LAST_EN
        // Early s_last on beat 3, sticky error through a later good frame, cleared by reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ifa.m_ready = 1'b0;
        for (int unsigned b = 0; b < 3; b++) begin
            drive_a(1'b1, 1'b0, b * WA);
            ifa.s_last = (b == 2);
            tick();
        end
        drive_a(1'b0, 1'b0, 0);
        ifa.s_last = 1'b0;
        repeat (3) tick();
        ifa.m_ready = 1'b1;
        tick();
        for (int unsigned b = 0; b < 5; b++) begin
            drive_a(1'b1, 1'b1, 0);
            ifa.s_last = (b == 4);
            tick();
        end
        drive_a(1'b0, 1'b0, 0);
        ifa.s_last = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
